hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  operation request from EX stage, sampled on clk rising edge.
REQ-004 SHALL have port op  input  3  opcode: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; others no-op.
REQ-005 SHALL have port a  input  32  rs operand (multiplicand/dividend/MTHI/MTLO data).
REQ-006 SHALL have port b  input  32  rt operand (multiplier/divisor).
REQ-007 SHALL have port flush  input  1  pipeline flush; aborts the in-flight operation.
REQ-008 SHALL have port busy  output  1  iterative operation in progress.
REQ-009 SHALL have port stall_req  output  1  combinational pipeline stall request.
REQ-010 SHALL have port done  output  1  one-cycle pulse when HI/LO are written by MULT/DIV.
REQ-011 SHALL have port hi  output  32  architectural HI register, feeds MEM-stage HI/LO forwarding.
REQ-012 SHALL have port lo  output  32  architectural LO register, feeds MEM-stage HI/LO forwarding.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-014 IDLE + start + MULT/MULTU SHALL go to MUL; IDLE + start + DIV/DIVU SHALL go to DIV; MUL/DIV SHALL go to FIX after 32 iteration cycles; FIX SHALL go to IDLE.
REQ-015 Operands SHALL be latched at the accepting edge; signed ops SHALL iterate on magnitudes and record result signs.
REQ-016 MUL SHALL perform 32 radix-2 shift-add steps producing a 64-bit product; DIV SHALL perform 32 restoring shift-subtract steps.
REQ-017 FIX SHALL apply sign correction and write hi/lo at its closing edge, with done=1 for exactly that following cycle.
REQ-018 Latency SHALL be fixed: start accepted at edge E0, busy=1 for exactly 33 cycles, hi/lo updated and done asserted at edge E33.
REQ-019 MULT/MULTU result SHALL be HI=product[63:32], LO=product[31:0].
REQ-020 DIV/DIVU SHALL give LO=quotient truncated toward zero, HI=remainder with sign of dividend.
REQ-021 Divide by zero SHALL give HI=a, LO=32'hFFFFFFFF, same 33-cycle latency.
REQ-022 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-023 MTHI/MTLO in IDLE SHALL write hi/lo at the next edge, no busy, no done.
REQ-024 start while busy SHALL be ignored; the pipeline holds the instruction via stall_req.
REQ-025 stall_req SHALL equal busy OR (start AND op in {MULT,MULTU,DIV,DIVU} AND state==IDLE).
REQ-026 flush SHALL return the FSM to IDLE at the next edge, deassert busy, suppress done, and leave hi/lo unchanged.
REQ-027 flush and start in the same cycle SHALL discard start, including MTHI/MTLO.
REQ-028 flush during FIX SHALL suppress the hi/lo write.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, hi=0, lo=0, busy=0, done=0, and clear iteration counter and operand latches, regardless of clk.
REQ-030 Reset during an operation SHALL discard it; no partial result SHALL ever reach hi/lo.

Structure
REQ-031 Opcode constants, FSM state encoding, and ITER_CNT=32 SHALL reside in shared package hilo_pkg.
REQ-032 One combinational sub-module, div_step (one restoring shift-subtract step), SHALL be instantiated; the multiply step SHALL be inline.

Verification
REQ-033 MULT a=32'hFFFFFFFD, b=7 -> after 33 busy cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse 1 cycle.
REQ-034 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-035 DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-036 DIV a=5, b=0 -> hi=5, lo=32'hFFFFFFFF; DIV 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-037 DIV started, flush on busy cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged; MTHI with start during busy -> hi unchanged.
REQ-038 rst_n pulsed low mid-MULT between edges -> hi=lo=0 and busy=0 immediately; next MTLO a=32'h1234 -> lo=32'h1234 one edge later.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared opcodes, FSM encoding and iteration count for the HI/LO multiply-divide unit.
package hilo_pkg;
  localparam int ITER_CNT = 32;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract division step.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] d,
  output logic [31:0] rem_n,
  output logic [31:0] quo_n
);
  logic [32:0] sh;
  logic ge;
  assign sh = {rem, quo[31]};
  assign ge = sh >= {1'b0, d};
  assign rem_n = ge ? 32'(sh - {1'b0, d}) : sh[31:0];
  assign quo_n = {quo[30:0], ge};
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-cycle multiply/divide unit owning the architectural HI/LO registers.
module hilo_muldiv
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t state;
  logic [4:0] cnt;
  logic [31:0] acc_hi, acc_lo, opb, dv_hi, dv_lo;
  logic neg_q, neg_r, dz, is_div, is_mul, is_md, sgn, last;
  logic [32:0] sum;
  logic [63:0] prod;
  assign is_mul = op == OP_MULT || op == OP_MULTU;
  assign is_md = is_mul || op == OP_DIV || op == OP_DIVU;
  assign sgn = op == OP_MULT || op == OP_DIV;
  assign last = cnt == 5'(ITER_CNT - 1);
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign busy = state != IDLE;
  assign stall_req = busy || (start && is_md && state == IDLE);
  div_step u_div_step (.rem(acc_hi), .quo(acc_lo), .d(opb), .rem_n(dv_hi), .quo_n(dv_lo));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      is_div <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (is_md) begin
            state <= is_mul ? MUL : DIV;
            cnt <= '0;
            acc_hi <= '0;
            acc_lo <= mag(a, sgn);
            opb <= mag(b, sgn);
            neg_q <= sgn && (a[31] ^ b[31]);
            neg_r <= sgn && a[31];
            dz <= b == '0;
            is_div <= !is_mul;
          end
          if (op == OP_MTHI) hi <= a;
          if (op == OP_MTLO) lo <= a;
        end
        MUL: begin
          acc_hi <= sum[32:1];
          acc_lo <= {sum[0], acc_lo[31:1]};
          cnt <= cnt + 5'd1;
          if (last) state <= FIX;
        end
        DIV: begin
          acc_hi <= dv_hi;
          acc_lo <= dv_lo;
          cnt <= cnt + 5'd1;
          if (last) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          done <= 1'b1;
          hi <= is_div ? (neg_r ? -acc_hi : acc_hi) : prod[63:32];
          lo <= is_div ? (dz ? '1 : (neg_q ? -acc_lo : acc_lo)) : prod[31:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed-vector self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, stall_req, done;
  logic [31:0] hi, lo;
  int vectors = 0, miscompares = 0;

  hilo_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 check({tag, " stall_req"}, 32'(stall_req), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, n, 33);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    check({tag, " done width"}, 32'(done), 32'd0);
  endtask

  task automatic move(input string tag, input logic [2:0] o, input logic [31:0] x, input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; a = x; flush = fl;
    #1 check({tag, " stall_req"}, 32'(stall_req), 32'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen;
    #12;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_op("mult", 3'b001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div neg", 3'b011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'b100, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div by zero", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div overflow", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("mult pos", 3'b001, 32'd12345, 32'd678, 32'd0, 32'd8369910);
    move("mthi", 3'b101, 32'h11111111, 1'b0);
    check("mthi hi", hi, 32'h11111111);
    move("mtlo", 3'b110, 32'h22222222, 1'b0);
    check("mtlo lo", lo, 32'h22222222);
    // DIV aborted by flush, with an MTHI attempted while busy
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        start = 1'b1; op = 3'b101; a = 32'hDEADBEEF;
        #1 check("mthi busy stall_req", 32'(stall_req), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen += int'(done);
    end
    check("flush no done", seen, 0);
    check("flush hi", hi, 32'h11111111);
    check("flush lo", lo, 32'h22222222);
    move("flush+mtlo", 3'b110, 32'h99, 1'b1);
    check("flush+mtlo lo", lo, 32'h22222222);
    // flush landing on the FIX cycle
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'd7; b = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 33; i++) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("fix flush done", 32'(done), 32'd0);
    check("fix flush busy", 32'(busy), 32'd0);
    check("fix flush hi", hi, 32'h11111111);
    check("fix flush lo", lo, 32'h22222222);
    // asynchronous reset mid-MULT
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async rst hi", hi, 32'h0);
    check("async rst lo", lo, 32'h0);
    check("async rst busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    move("mtlo after rst", 3'b110, 32'h1234, 1'b0);
    check("mtlo after rst lo", lo, 32'h1234);
    check("mtlo after rst hi", hi, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
